// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: decode-stage stall/bypass control with a load scoreboard for variable-latency loads.
// Optional HAZARD_PERF_COUNTERS_EN adds stall/bypass performance counters.
module hazard_scoreboard_unit #(
  parameter int NUM_SRC         = 2,
  parameter int REG_ADDR_W      = 5,
  parameter int MAX_OUTSTANDING = 2,
  parameter int NUM_REGS        = 2**REG_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_i,
  input  logic [NUM_SRC-1:0]            src_read_i,
  input  logic                          regwrite_execute_i,
  input  logic                          regwrite_memory_i,
  input  logic                          regwrite_writeback_i,
  input  logic [REG_ADDR_W-1:0]         rd_execute_i,
  input  logic [REG_ADDR_W-1:0]         rd_memory_i,
  input  logic [REG_ADDR_W-1:0]         rd_writeback_i,
  input  logic                          is_load_execute_i,
  input  logic                          advance_execute_i,
  input  logic                          load_resp_valid_i,
  input  logic [REG_ADDR_W-1:0]         load_resp_rd_i,
  output logic [2*NUM_SRC-1:0]          src_bypass_o,
  output logic                          stall_needed_o,
  output logic [NUM_REGS-1:0]           pending_mask_o,
  output logic                          protocol_error_o
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0]                   stall_cycles_o,
  output logic [31:0]                   load_stall_cycles_o,
  output logic [31:0]                   bypass_events_o
`endif
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                perr_q, perr_d;
  logic [NUM_SRC-1:0]  load_hit, sb_hit;
  logic [2*NUM_SRC-1:0] byp_raw;
  logic structural, issue, resp_hit, load_stall;
  assign structural = is_load_execute_i && (cnt_q == MAX_CNT);
  assign issue      = is_load_execute_i && regwrite_execute_i && advance_execute_i &&
                      (rd_execute_i != '0) && !structural;
  assign resp_hit   = load_resp_valid_i && pending_q[load_resp_rd_i];
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_ADDR_W-1:0] a;
    logic act, ex_m, mem_m, wb_m;
    assign a     = src_addr_i[i*REG_ADDR_W +: REG_ADDR_W];
    assign act   = src_read_i[i] && (a != '0);
    assign ex_m  = act && regwrite_execute_i && (rd_execute_i == a);
    assign mem_m = act && regwrite_memory_i && (rd_memory_i == a);
    assign wb_m  = act && regwrite_writeback_i && (rd_writeback_i == a);
    assign load_hit[i] = ex_m && is_load_execute_i;
    assign sb_hit[i]   = act && pending_q[a];
    assign byp_raw[2*i +: 2] = ex_m ? 2'b01 : mem_m ? 2'b10 : wb_m ? 2'b11 : 2'b00;
  end
  assign load_stall     = |load_hit || |sb_hit;
  assign stall_needed_o = !rst_n || load_stall || structural;
  assign src_bypass_o   = stall_needed_o ? '0 : byp_raw;
  assign pending_mask_o = pending_q;
  assign protocol_error_o = perr_q;
  // Response clears before issue sets, so a same-register issue+response leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (resp_hit) pending_d[load_resp_rd_i] = 1'b0;
    if (issue) pending_d[rd_execute_i] = 1'b1;
    cnt_d = (issue && !resp_hit && cnt_q != MAX_CNT) ? cnt_q + 1'b1 :
            (resp_hit && !issue && cnt_q != '0)      ? cnt_q - 1'b1 : cnt_q;
    perr_d = perr_q || (load_resp_valid_i && !pending_q[load_resp_rd_i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      perr_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      perr_q    <= perr_d;
    end
  end
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cnt_q, load_stall_cnt_q, byp_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q      <= '0;
      load_stall_cnt_q <= '0;
      byp_cnt_q        <= '0;
    end else begin
      stall_cnt_q      <= stall_cnt_q + 32'(stall_needed_o);
      load_stall_cnt_q <= load_stall_cnt_q + 32'(load_stall);
      byp_cnt_q        <= byp_cnt_q + 32'(|src_bypass_o);
    end
  end
  assign stall_cycles_o      = stall_cnt_q;
  assign load_stall_cycles_o = load_stall_cnt_q;
  assign bypass_events_o     = byp_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed checks of stall, bypass and scoreboard behaviour.
module tb_hazard_scoreboard_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  src_addr;
  logic [1:0]  src_read;
  logic        rw_ex, rw_mem, rw_wb;
  logic [4:0]  rd_ex, rd_mem, rd_wb;
  logic        is_load, adv, resp_v;
  logic [4:0]  resp_rd;
  logic [3:0]  bypass;
  logic        stall;
  logic [31:0] pending;
  logic        perr;
  int n_cmp = 0;
  int n_err = 0;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles, load_stall_cycles, bypass_events;
`endif
  hazard_scoreboard_unit dut (
    .clk(clk), .rst_n(rst_n), .src_addr_i(src_addr), .src_read_i(src_read),
    .regwrite_execute_i(rw_ex), .regwrite_memory_i(rw_mem), .regwrite_writeback_i(rw_wb),
    .rd_execute_i(rd_ex), .rd_memory_i(rd_mem), .rd_writeback_i(rd_wb),
    .is_load_execute_i(is_load), .advance_execute_i(adv),
    .load_resp_valid_i(resp_v), .load_resp_rd_i(resp_rd),
    .src_bypass_o(bypass), .stall_needed_o(stall), .pending_mask_o(pending),
    .protocol_error_o(perr)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .stall_cycles_o(stall_cycles), .load_stall_cycles_o(load_stall_cycles),
    .bypass_events_o(bypass_events)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    src_addr = '0; src_read = '0;
    rw_ex = 0; rw_mem = 0; rw_wb = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
    is_load = 0; adv = 0; resp_v = 0; resp_rd = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_ex(input logic [4:0] rd, input logic a);
    is_load = 1; rw_ex = 1; rd_ex = rd; adv = a;
  endtask
  initial begin
    idle();
    rst_n = 0;
    src_addr = {5'd3, 5'd3}; src_read = 2'b11; rw_ex = 1; rd_ex = 3;
    #1;
    chk("rst_stall", stall, 1);
    chk("rst_bypass", bypass, 0);
    chk("rst_pending", pending, 0);
    chk("rst_perr", perr, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    idle();
    // load-use on x5
    load_ex(5, 1); src_addr = {5'd0, 5'd5}; src_read = 2'b01;
    #1;
    chk("lu_stall_N", stall, 1);
    chk("lu_bypass_N", bypass, 0);
    tick();
    is_load = 0; rw_ex = 0; rd_ex = 0; adv = 0;
    #1;
    chk("lu_pending_N1", pending, 32'h20);
    chk("lu_stall_N1", stall, 1);
    resp_v = 1; resp_rd = 5;
    #1;
    chk("lu_stall_M", stall, 1);
    tick();
    resp_v = 0; rw_wb = 1; rd_wb = 5;
    #1;
    chk("lu_stall_M1", stall, 0);
    chk("lu_bypass_M1", bypass, 4'b0011);
    chk("lu_pending_M1", pending, 0);
    // forwarding priority
    idle();
    rw_ex = 1; rd_ex = 7; rw_mem = 1; rd_mem = 7; src_addr = {5'd7, 5'd0}; src_read = 2'b10;
    #1;
    chk("fwd_ex_stall", stall, 0);
    chk("fwd_ex_bypass", bypass, 4'b0100);
    src_read = 2'b00;
    #1;
    chk("fwd_noread_bypass", bypass, 0);
    chk("fwd_noread_stall", stall, 0);
    idle();
    rw_mem = 1; rd_mem = 8; rw_wb = 1; rd_wb = 8; src_addr = {5'd8, 5'd8}; src_read = 2'b11;
    #1;
    chk("fwd_mem_bypass", bypass, 4'b1010);
    rd_mem = 9;
    #1;
    chk("fwd_wb_bypass", bypass, 4'b1111);
    // x0 never hazards and a load to x0 never issues
    idle();
    load_ex(0, 1); src_addr = {5'd0, 5'd0}; src_read = 2'b01;
    #1;
    chk("x0_stall", stall, 0);
    chk("x0_bypass", bypass, 0);
    tick();
    chk("x0_pending", pending, 0);
    // structural limit
    idle();
    load_ex(3, 1);
    tick();
    load_ex(4, 1);
    tick();
    chk("st_pending", pending, 32'h18);
    load_ex(6, 0);
    #1;
    chk("st_stall_full", stall, 1);
    tick();
    chk("st_pending_hold", pending, 32'h18);
    resp_v = 1; resp_rd = 3;
    #1;
    chk("st_stall_resp", stall, 1);
    tick();
    resp_v = 0;
    #1;
    chk("st_pending_resp", pending, 32'h10);
    chk("st_stall_free", stall, 0);
    adv = 1;
    tick();
    chk("st_pending_issue", pending, 32'h50);
    idle();
    resp_v = 1; resp_rd = 4;
    tick();
    resp_rd = 6;
    tick();
    resp_v = 0;
    chk("st_drained", pending, 0);
    chk("st_perr", perr, 0);
    // same-cycle issue and response to x9
    load_ex(9, 1);
    tick();
    resp_v = 1; resp_rd = 9;
    tick();
    resp_v = 0;
    chk("same_pending", pending, 32'h200);
    load_ex(10, 0);
    #1;
    chk("same_cnt_one", stall, 0);
    adv = 1;
    tick();
    chk("same_pending2", pending, 32'h600);
    load_ex(11, 0);
    #1;
    chk("same_cnt_two", stall, 1);
    idle();
    resp_v = 1; resp_rd = 12;
    tick();
    resp_v = 0;
    chk("perr_set", perr, 1);
    chk("perr_pending", pending, 32'h600);
    tick();
    tick();
    chk("perr_sticky", perr, 1);
    // async reset mid-flight
    #2;
    rst_n = 0;
    src_addr = {5'd0, 5'd3}; src_read = 2'b01; rw_ex = 1; rd_ex = 3;
    #1;
    chk("ar_pending", pending, 0);
    chk("ar_stall", stall, 1);
    chk("ar_bypass", bypass, 0);
    chk("ar_perr", perr, 0);
    @(negedge clk);
    rst_n = 1;
    idle();
    src_addr = {5'd9, 5'd3}; src_read = 2'b11;
    #1;
    chk("post_stall", stall, 0);
    chk("post_bypass", bypass, 0);
    tick();
    chk("post_pending", pending, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
